// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the 64-bit RISC-V datapath:
//               datapath width, canonical NOP encoding, fetch-FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // request outstanding at pc
        HOLD  = 2'd1,  // skid buffer occupied, no request issued
        DRAIN = 2'd2   // waiting out a wrong-path response before redirect
    } fetch_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register holding valid, PC and instruction.
//               Priority: flush > load > hold. Without load or hold the
//               entry is treated as consumed and valid drops.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               i_flush           squash entry (valid=0, instr=NOP)
//               i_load            capture i_pc / i_instr
//               i_hold            decode stalled, keep current entry
//               o_valid/o_pc/o_instr  register contents
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic            i_hold,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instr
);
    import riscv_pkg::*;

    logic            r_valid_q;
    logic [XLEN-1:0] r_pc_q;
    logic [31:0]     r_instr_q;

    logic            w_valid_d;
    logic [XLEN-1:0] w_pc_d;
    logic [31:0]     w_instr_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        if (i_flush) begin
            w_valid_d = 1'b0;
            w_instr_d = NOP_INSTR;
        end else if (i_load) begin
            w_valid_d = 1'b1;
            w_pc_d    = i_pc;
            w_instr_d = i_instr;
        end else if (!i_hold) begin
            // Entry consumed by decode with nothing behind it.
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_pc_q    <= '0;
            r_instr_q <= NOP_INSTR;
        end else begin
            r_valid_q <= w_valid_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_pc    = r_pc_q;
    assign o_instr = r_instr_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : Instruction fetch unit plus IF/ID pipeline register. Owns the
//               PC, issues one word fetch at a time over a ready handshake,
//               absorbs decode stalls in a one-entry skid buffer and squashes
//               wrong-path instructions on a taken branch.
// Ports       : clk, reset               clock, async active-high reset
//               imem_req/imem_addr       fetch request and address
//               imem_ready/imem_rdata    fetch completion and data
//               stall                    decode cannot consume IF/ID
//               branch_taken/target      redirect from EX
//               id_valid/id_pc/id_instruction  IF/ID contents to decode
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instruction
);
    import riscv_pkg::*;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    fetch_state_e    r_state_q,      w_state_d;
    logic [XLEN-1:0] r_pc_q,         w_pc_d;
    logic [XLEN-1:0] r_redir_pc_q,   w_redir_pc_d;
    // Skid contents are meaningful only while in HOLD; leaving HOLD empties it.
    logic [XLEN-1:0] r_skid_pc_q,    w_skid_pc_d;
    logic [31:0]     r_skid_instr_q, w_skid_instr_d;

    logic            w_accept;
    logic            w_load;
    logic [XLEN-1:0] w_load_pc;
    logic [31:0]     w_load_instr;
    logic [XLEN-1:0] w_target;
    logic            w_unused_target_lsbs;

    // Instructions are word aligned; the low target bits carry no information.
    assign w_target             = {branch_target[XLEN-1:2], 2'b00};
    assign w_unused_target_lsbs = ^branch_target[1:0];

    assign w_accept = !id_valid || !stall;

    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_redir_pc_d   = r_redir_pc_q;
        w_skid_pc_d    = r_skid_pc_q;
        w_skid_instr_d = r_skid_instr_q;
        w_load         = 1'b0;
        w_load_pc      = r_pc_q;
        w_load_instr   = imem_rdata;

        case (r_state_q)
            FETCH: begin
                if (branch_taken) begin
                    if (imem_ready) begin
                        // Response is wrong-path; drop it and refetch at target.
                        w_pc_d = w_target;
                    end else begin
                        // Request still in flight and its address must stay
                        // stable; remember where to go once it completes.
                        w_redir_pc_d = w_target;
                        w_state_d    = DRAIN;
                    end
                end else if (imem_ready) begin
                    w_pc_d = r_pc_q + c_pc_step;
                    if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_skid_pc_d    = r_pc_q;
                        w_skid_instr_d = imem_rdata;
                        w_state_d      = HOLD;
                    end
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    w_pc_d    = w_target;
                    w_state_d = FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_pc    = r_skid_pc_q;
                    w_load_instr = r_skid_instr_q;
                    w_state_d    = FETCH;
                end
            end

            DRAIN: begin
                if (imem_ready) begin
                    // A redirect arriving with the response is the youngest.
                    w_pc_d    = branch_taken ? w_target : r_redir_pc_q;
                    w_state_d = FETCH;
                end else if (branch_taken) begin
                    w_redir_pc_d = w_target;
                end
            end

            default: begin
                w_state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= FETCH;
            r_pc_q         <= RESET_PC;
            r_redir_pc_q   <= '0;
            r_skid_pc_q    <= '0;
            r_skid_instr_q <= NOP_INSTR;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_redir_pc_q   <= w_redir_pc_d;
            r_skid_pc_q    <= w_skid_pc_d;
            r_skid_instr_q <= w_skid_instr_d;
        end
    end

    // Reset gates the request directly so it drops the moment reset rises,
    // abandoning any outstanding response.
    assign imem_req  = !reset && (r_state_q != HOLD);
    assign imem_addr = r_pc_q;

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (reset),
        .i_flush (branch_taken),
        .i_load  (w_load),
        .i_hold  (stall),
        .i_pc    (w_load_pc),
        .i_instr (w_load_instr),
        .o_valid (id_valid),
        .o_pc    (id_pc),
        .o_instr (id_instruction)
    );

endmodule : if_id_stage
`default_nettype wire
